dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Load/store sequencer between the MEM pipeline stage and a single-port, synchronous-read data memory of NUM_WORDS 32-bit words. The block performs the following steps for each request:
- accepts one request at a time over a valid/ready handshake;
- checks alignment and range;
- drives the memory port with byte enables;
- sign- or zero-extends load data;
- returns one registered response pulse.

The pipeline stalls on `req_valid & ~req_ready`.

## Interface
- NUM_WORDS, 32, data memory depth in words
- ADDR_W, $clog2(NUM_WORDS), word-address width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM stage has a load/store
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Reset state is IDLE.
- **IDLE:** req_ready=1. A request is accepted on `req_valid & req_ready`. The controller latches we, funct3, addr and wdata.
  - Error condition: the request has an error if any of the following holds:
    - H/HU/SH with addr[0]=1;
    - W/SW with addr[1:0]≠0;
    - addr[31:2] ≥ NUM_WORDS;
    - funct3 ∈ {011, 110, 111};
    - a store with funct3 ∈ {100, 101}.
  - Transitions: error → RESP (no memory access). Otherwise → ACCESS.
- **ACCESS:** mem_en=1 and mem_we=req_we, with mem_be/mem_addr/mem_wdata from the latched request. Store → RESP. Load → WAIT.
- **WAIT:** sample mem_rdata, extract, extend and register it into the response data. → RESP.
- **RESP:** rsp_valid=1 with rsp_rdata/rsp_err. → IDLE.
- Byte lanes for stores (o = addr[1:0]):
  - SB: be = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111, wdata unchanged.
- Loads: select the lane as rdata >> (8·o). Then:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: data unchanged.
  - mem_be=4'b1111 on reads.
- Memory signals other than those in ACCESS are 0 (mem_en, mem_we, mem_be, mem_addr, mem_wdata).
- req_valid/req_* changes while not in IDLE are ignored.

## Timing
- Accept in cycle T:
  - load: mem_en at T+1, rsp_valid at T+3;
  - store: write at T+1, rsp_valid at T+2;
  - error: rsp_valid at T+1.
- req_ready returns high at the cycle after rsp_valid, so back-to-back loads issue every 4 cycles.
- All outputs are registered or decoded from state only. No combinational path from req_* to mem_* or rsp_*.
- Reset values: req_ready=1 (IDLE); rsp_valid, rsp_err, mem_en and mem_we are 0; rsp_rdata, mem_be, mem_addr and mem_wdata are all 0.
- Reset mid-operation → IDLE immediately. Under reset, no write is issued and no response is emitted for the aborted request.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum dmem_state_t.
- Sub-module lsu_align (combinational) computes be/wdata replication for stores and lane select plus extension for loads. The FSM and registers stay in dmem_ctrl.

## Test plan
- SW addr 0x8, wdata 0xDEADBEEF → T+1: mem_en=1, mem_we=1, be=1111, mem_addr=2; T+2: rsp_valid, err=0.
- SB addr 0x6, wdata 0x000000A5 → be=0100, mem_wdata=0xA5A5A5A5. Then LB 0x6 with mem_rdata 0x00A50000 → rsp_rdata=0xFFFFFFA5 at T+3; LBU → 0x000000A5.
- LH addr 0xA with mem_rdata 0x8001_0000 → 0xFFFF8001; LHU → 0x00008001.
- LW addr 0x2 → rsp_err=1 at T+1, mem_en never asserted. LW addr 0x80 (NUM_WORDS=32) → err. funct3=011 → err.
- req_valid held high for two loads → req_ready low in ACCESS/WAIT/RESP. The second load is accepted exactly 4 cycles after the first.
- n_rst asserted in ACCESS of a store → mem_en drops asynchronously, no rsp_valid. After release, req_ready=1 and all outputs are 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store sequencer.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response and memory-port bundle between the MEM stage, dmem_ctrl and the data memory.
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int NUM_WORDS = 32
);
    localparam int ADDR_W = $clog2(NUM_WORDS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering: store enables/replication and load lane select plus extension.
module lsu_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        if (we) begin
            case (funct3)
                F3_B: begin
                    be        = 4'b0001 << offset;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be        = offset[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_data = shifted;
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port synchronous-read data memory.
// state  | meaning
// IDLE   | ready for a request; latches it on accept
// ACCESS | drives the memory port from the latched request
// WAIT   | captures and extends read data
// RESP   | one-cycle response pulse
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int NUM_WORDS = 32
)(
    input  logic   clk,
    input  logic   n_rst,
    dmem_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_WORDS);

    dmem_state_t       state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       ld_data;

    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            F3_B:    req_err = 1'b0;
            F3_BU:   req_err = bus.req_we;
            F3_H:    req_err = bus.req_addr[0];
            F3_HU:   req_err = bus.req_we | bus.req_addr[0];
            F3_W:    req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= 32'(NUM_WORDS)) req_err = 1'b1;
    end

    lsu_align u_align (
        .we        (we_q),
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus.mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr[ADDR_W+1:0];
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
                rdata_q <= 32'h0;
            end
            if (state_q == WAIT) rdata_q <= ld_data;
        end
    end

    // Outputs decode from state and latched registers only, never from req_*.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_be     = 4'b0000;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 32'h0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_err    = 1'b0;
        bus.rsp_rdata  = 32'h0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_be    = be;
                bus.mem_addr  = addr_q[ADDR_W+1:2];
                bus.mem_wdata = we_q ? wdata_rep : 32'h0;
                state_d       = we_q ? RESP : WAIT;
            end
            WAIT: state_d = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a driver queues expected memory accesses and responses, a monitor checks them.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    mem_exp_t mq[$];
    rsp_exp_t rq[$];

    logic [31:0] tbmem [32] = '{default: 32'h0};

    dmem_if #(.NUM_WORDS(32)) bus ();

    dmem_ctrl #(.NUM_WORDS(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read, byte-enabled data memory model
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be[i]) tbmem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end else begin
                bus.mem_rdata <= tbmem[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        mem_exp_t m;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (mq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_unexpected: got mem_en=1 expected no access (cycle %0d)", cyc);
                end else begin
                    m = mq.pop_front();
                    chk("mem_cycle", 32'(cyc), 32'(m.cyc));
                    chk("mem_we", {31'h0, bus.mem_we}, {31'h0, m.we});
                    chk("mem_be", {28'h0, bus.mem_be}, {28'h0, m.be});
                    chk("mem_addr", {27'h0, bus.mem_addr}, {27'h0, m.addr});
                    if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
            if (bus.rsp_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, r.err});
                    chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || mq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_pending", 32'(rq.size()), 32'd0);
        chk("mem_pending", 32'(mq.size()), 32'd0);
        rq.delete();
        mq.delete();
    endtask

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_mwdata);
        int k;
        int lat;
        @(negedge clk);
        chk({name, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
        drive(we, f3, addr, wdata);
        k = cyc;
        lat = exp_err ? 1 : (we ? 2 : 3);
        if (!exp_err) mq.push_back('{we, exp_be, addr[6:2], exp_mwdata, k + 1});
        rq.push_back('{exp_rdata, exp_err, k + lat});
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_mem_en"}, {31'h0, bus.mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'd0);
        chk({tag, "_mem_be"}, {28'h0, bus.mem_be}, 32'd0);
        chk({tag, "_mem_addr"}, {27'h0, bus.mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin : driver
        int k;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        @(negedge clk);
        chk_idle_outputs("in_reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        //     name     we    f3     addr          wdata         rdata         err   be       mem_wdata
        issue("sw_8",   1'b1, F3_W,  32'h0000_0008, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF);
        issue("lw_8",   1'b0, F3_W,  32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0);
        issue("sb_6",   1'b1, F3_B,  32'h0000_0006, 32'h0000_00A5, 32'h0,        1'b0, 4'b0100, 32'hA5A5_A5A5);
        issue("lb_6",   1'b0, F3_B,  32'h0000_0006, 32'h0,         32'hFFFF_FFA5, 1'b0, 4'b1111, 32'h0);
        issue("lbu_6",  1'b0, F3_BU, 32'h0000_0006, 32'h0,         32'h0000_00A5, 1'b0, 4'b1111, 32'h0);
        issue("sw_8b",  1'b1, F3_W,  32'h0000_0008, 32'h8001_0000, 32'h0,        1'b0, 4'b1111, 32'h8001_0000);
        issue("lh_a",   1'b0, F3_H,  32'h0000_000A, 32'h0,         32'hFFFF_8001, 1'b0, 4'b1111, 32'h0);
        issue("lhu_a",  1'b0, F3_HU, 32'h0000_000A, 32'h0,         32'h0000_8001, 1'b0, 4'b1111, 32'h0);
        issue("sh_2",   1'b1, F3_H,  32'h0000_0002, 32'h1234_ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD);
        issue("lw_0",   1'b0, F3_W,  32'h0000_0000, 32'h0,         32'hABCD_0000, 1'b0, 4'b1111, 32'h0);
        issue("lb_3",   1'b0, F3_B,  32'h0000_0003, 32'h0,         32'hFFFF_FFAB, 1'b0, 4'b1111, 32'h0);
        issue("lhu_0",  1'b0, F3_HU, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 4'b1111, 32'h0);
        issue("sw_7c",  1'b1, F3_W,  32'h0000_007C, 32'h0000_0001, 32'h0,        1'b0, 4'b1111, 32'h0000_0001);
        issue("lw_7c",  1'b0, F3_W,  32'h0000_007C, 32'h0,         32'h0000_0001, 1'b0, 4'b1111, 32'h0);
        issue("lw_mis", 1'b0, F3_W,  32'h0000_0002, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0);
        issue("lw_oor", 1'b0, F3_W,  32'h0000_0080, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0);
        issue("f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        issue("f3_111", 1'b0, 3'b111, 32'h0000_0004, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        issue("sbu",    1'b1, F3_BU, 32'h0000_0000, 32'h0000_0055, 32'h0,        1'b1, 4'b0000, 32'h0);
        issue("lh_1",   1'b0, F3_H,  32'h0000_0001, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0);

        // Back-to-back: req_valid held, second load accepted 4 cycles after the first
        @(negedge clk);
        chk("b2b_ready0", {31'h0, bus.req_ready}, 32'd1);
        drive(1'b0, F3_W, 32'h0000_0008, 32'h0);
        k = cyc;
        mq.push_back('{1'b0, 4'b1111, 5'd2, 32'h0, k + 1});
        rq.push_back('{32'h8001_0000, 1'b0, k + 3});
        mq.push_back('{1'b0, 4'b1111, 5'd1, 32'h0, k + 5});
        rq.push_back('{32'h0000_00A5, 1'b0, k + 7});
        @(negedge clk);
        chk("b2b_ready_access", {31'h0, bus.req_ready}, 32'd0);
        drive(1'b0, F3_BU, 32'h0000_0006, 32'h0);
        @(negedge clk);
        chk("b2b_ready_wait", {31'h0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_resp", {31'h0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_idle", {31'h0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_ready_busy2", {31'h0, bus.req_ready}, 32'd0);
        drain();

        // Reset during ACCESS of a store: no write, no response
        @(negedge clk);
        drive(1'b1, F3_W, 32'h0000_000C, 32'h5555_5555);
        k = cyc;
        mq.push_back('{1'b1, 4'b1111, 5'd3, 32'h5555_5555, k + 1});
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        chk("rst_pre_mem_en", {31'h0, bus.mem_en}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_async_mem_en", {31'h0, bus.mem_en}, 32'd0);
        chk("rst_async_mem_we", {31'h0, bus.mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_release");
        repeat (5) @(negedge clk);
        chk("rst_no_write", tbmem[3], 32'h0);
        chk("rst_mem_q", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
